// File: rtl/de_mem_scheduler.sv
`timescale 1ns/1ps
// ============================================================================
// de_mem_scheduler
// ----------------------------------------------------------------------------
// Command queue and request sequencer between the drawing engine and the de_*
// client port of drawing_mem_ctrl. Commands are buffered in a small FIFO and
// issued strictly in order over the controller's req/ack handshake. Read data
// is returned with a one-cycle rsp_valid pulse. Starvation and transfer
// statistics are also reported.
//
// Ports
//   clk, nreset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         drawing-engine command handshake
//   cmd_rnw, cmd_address,
//   cmd_nbyte, cmd_wdata        command payload (nbyte is active-low)
//   rsp_valid, rsp_data         read result, one-cycle pulse / held data
//   de_req/de_ack               request / acknowledge to the memory controller
//   de_address, de_nbyte,
//   de_rnw, de_wdata            head-of-queue command to the memory controller
//   de_rdata                    read data from the memory controller
//   busy                        queue non-empty
//   starve                      request outstanding for STARVE_LIMIT cycles
//   stat_clear                  synchronous clear of wr_count / rd_count
//   wr_count, rd_count          saturating completed-transfer counters
// ============================================================================
module de_mem_scheduler #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clk,
    input  logic        nreset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [17:0] cmd_address,
    input  logic [3:0]  cmd_nbyte,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_data,

    output logic        de_req,
    input  logic        de_ack,
    output logic [17:0] de_address,
    output logic [3:0]  de_nbyte,
    output logic        de_rnw,
    output logic [31:0] de_wdata,
    input  logic [31:0] de_rdata,

    output logic        busy,
    output logic        starve,
    input  logic        stat_clear,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic        rnw;
        logic [17:0] address;
        logic [3:0]  nbyte;
        logic [31:0] wdata;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            starve_q, starve_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     wr_count_q, wr_count_d;
    logic [15:0]     rd_count_q, rd_count_d;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    entry_t          head_entry;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    // Ready depends on the registered count only: a full queue does not accept
    // a command in the same cycle that an entry retires.
    assign cmd_ready  = (count_q != DEPTH_C);
    assign push       = cmd_valid && cmd_ready;
    assign de_req     = !fifo_empty;
    // An ack while nothing is requested is ignored.
    assign pop        = de_req && de_ack;

    // ------------------------------------------------------------------------
    // Storage: written at the tail, head read combinationally so the next
    // entry is on de_* the cycle after a pop, ahead of the next arbitration.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail_q] <= '{rnw:     cmd_rnw,
                                   address: cmd_address,
                                   nbyte:   cmd_nbyte,
                                   wdata:   cmd_wdata};
        end
    end

    assign head_entry = fifo_mem[head_q];

    // Outputs are masked while empty so they show a zeroed entry with all
    // byte lanes disabled instead of stale storage contents.
    assign de_rnw     = fifo_empty ? 1'b0    : head_entry.rnw;
    assign de_address = fifo_empty ? 18'h0   : head_entry.address;
    assign de_nbyte   = fifo_empty ? 4'b1111 : head_entry.nbyte;
    assign de_wdata   = fifo_empty ? 32'h0   : head_entry.wdata;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        wr_count_d   = wr_count_q;
        rd_count_d   = rd_count_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Read completion captures the data on the edge that ends the ack.
        if (pop && head_entry.rnw) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = de_rdata;
        end

        // Starvation: counts waiting request cycles, restarts on every pop.
        if (pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (de_req && !de_ack && (starve_cnt_q != STARVE_C)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        // Clear wins over a same-cycle increment.
        if (stat_clear) begin
            wr_count_d = '0;
            rd_count_d = '0;
        end else if (pop) begin
            if (head_entry.rnw) begin
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_d = rd_count_q + 16'd1;
                end
            end else begin
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_d = wr_count_q + 16'd1;
                end
            end
        end
    end

    assign starve_d = (starve_cnt_d == STARVE_C);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
        end
    end

    assign busy      = !fifo_empty;
    assign starve    = starve_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_de_mem_scheduler.sv
`timescale 1ns/1ps
// ============================================================================
// tb_de_mem_scheduler
// Directed stimulus with a scoreboard: every queued command pushes its
// expected de_* transfer, every read pushes its expected response; a monitor
// pops and compares whenever the DUT completes a transfer or pulses rsp_valid.
// ============================================================================
module tb_de_mem_scheduler;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [17:0] cmd_address = '0;
    logic [3:0]  cmd_nbyte = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        de_req;
    logic        de_ack = 1'b0;
    logic [17:0] de_address;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_wdata;
    logic [31:0] de_rdata = '0;
    logic        busy;
    logic        starve;
    logic        stat_clear = 1'b0;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    always #5 clk = ~clk;

    de_mem_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rnw    (cmd_rnw),
        .cmd_address(cmd_address),
        .cmd_nbyte  (cmd_nbyte),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .de_req     (de_req),
        .de_ack     (de_ack),
        .de_address (de_address),
        .de_nbyte   (de_nbyte),
        .de_rnw     (de_rnw),
        .de_wdata   (de_wdata),
        .de_rdata   (de_rdata),
        .busy       (busy),
        .starve     (starve),
        .stat_clear (stat_clear),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    typedef struct packed {
        logic        rnw;
        logic [17:0] addr;
        logic [3:0]  nbyte;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        exp_issue[$];
    logic [31:0] exp_rsp[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    cmd_t        mon_e;
    logic [31:0] mon_r;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rnw, input logic [17:0] a,
                            input logic [3:0] nb, input logic [31:0] wd);
        check("push_ready", {63'b0, cmd_ready}, 64'd1);
        cmd_valid   = 1'b1;
        cmd_rnw     = rnw;
        cmd_address = a;
        cmd_nbyte   = nb;
        cmd_wdata   = wd;
        exp_issue.push_back({rnw, a, nb, wd});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic ack_cycle(input logic [31:0] rd);
        de_ack   = 1'b1;
        de_rdata = rd;
        tick();
        de_ack   = 1'b0;
        de_rdata = '0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (nreset && de_req && de_ack) begin
            if (exp_issue.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL xfer_unexpected: got addr %05h expected no transfer", de_address);
            end else begin
                mon_e = exp_issue.pop_front();
                check("xfer", {9'b0, de_rnw, de_address, de_nbyte, de_wdata}, {9'b0, mon_e});
                $display("xfer rnw=%0b addr=%05h nbyte=%04b wdata=%08h",
                         de_rnw, de_address, de_nbyte, de_wdata);
            end
        end
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got rsp_data %08h expected no response", rsp_data);
            end else begin
                mon_r = exp_rsp.pop_front();
                check("rsp", {32'b0, rsp_data}, {32'b0, mon_r});
                $display("rsp data=%08h", rsp_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          req_cycles;
        int          nxt;
        logic        acc;
        cmd_t        cur;

        // ---------------- reset state ----------------
        #2;
        check("rst_de_req",    {63'b0, de_req},    64'd0);
        check("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_rsp_data",  {32'b0, rsp_data},  64'd0);
        check("rst_busy",      {63'b0, busy},      64'd0);
        check("rst_starve",    {63'b0, starve},    64'd0);
        check("rst_counts",    {32'b0, wr_count, rd_count}, 64'd0);
        check("rst_de_bus",    {9'b0, de_rnw, de_address, de_nbyte, de_wdata},
                               {9'b0, 1'b0, 18'h0, 4'b1111, 32'h0});
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        tick();

        // ---------------- single write ----------------
        push_cmd(1'b0, 18'h00123, 4'b0000, 32'hDEADBEEF);
        check("w1_req",  {63'b0, de_req}, 64'd1);
        check("w1_busy", {63'b0, busy},   64'd1);
        tick();
        ack_cycle(32'h0);
        check("w1_req_after",  {63'b0, de_req}, 64'd0);
        check("w1_busy_after", {63'b0, busy},   64'd0);
        check("w1_wr_count",   {48'b0, wr_count}, 64'd1);

        // ---------------- back-to-back ----------------
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 18'(i), 4'(i), 32'h1000_0000 + 32'(i));
        end
        check("b2b_full_ready", {63'b0, cmd_ready}, 64'd0);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (de_req) req_cycles++;
            tick();
            if (de_req) req_cycles++;
            ack_cycle(32'h0);
            if (i == 0) check("b2b_ready_after_pop", {63'b0, cmd_ready}, 64'd1);
        end
        check("b2b_req_cycles", 64'(req_cycles), 64'd8);
        check("b2b_req_done",   {63'b0, de_req}, 64'd0);
        check("b2b_wr_count",   {48'b0, wr_count}, 64'd5);

        // ---------------- read ----------------
        push_cmd(1'b1, 18'h3FFFF, 4'b0000, 32'h0);
        exp_rsp.push_back(32'hA5A5_5A5A);
        tick();
        ack_cycle(32'hA5A5_5A5A);
        check("rd_valid_pulse", {63'b0, rsp_valid}, 64'd1);
        check("rd_data",        {32'b0, rsp_data},  64'hA5A5_5A5A);
        tick();
        check("rd_valid_end",   {63'b0, rsp_valid}, 64'd0);
        check("rd_data_hold",   {32'b0, rsp_data},  64'hA5A5_5A5A);
        check("rd_rd_count",    {48'b0, rd_count},  64'd1);

        // ---------------- ack while idle is ignored ----------------
        ack_cycle(32'h1234_5678);
        check("idle_ack_rsp",    {63'b0, rsp_valid}, 64'd0);
        check("idle_ack_counts", {32'b0, wr_count, rd_count}, {32'b0, 16'd5, 16'd1});

        // ---------------- full and wrap ----------------
        nxt = 0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 18'h100 + 18'(nxt), 4'(nxt), 32'hC000_0000 + 32'(nxt));
            nxt++;
        end
        check("wrap_full_ready", {63'b0, cmd_ready}, 64'd0);
        cmd_valid   = 1'b1;
        cmd_rnw     = 1'b0;
        cmd_address = 18'h100 + 18'(nxt);
        cmd_nbyte   = 4'(nxt);
        cmd_wdata   = 32'hC000_0000 + 32'(nxt);
        for (int k = 0; k < 10; k++) begin
            de_ack = (k % 2 == 0);
            acc    = cmd_valid && cmd_ready;
            cur    = {cmd_rnw, cmd_address, cmd_nbyte, cmd_wdata};
            tick();
            de_ack = 1'b0;
            if (acc) begin
                exp_issue.push_back(cur);
                nxt++;
                cmd_address = 18'h100 + 18'(nxt);
                cmd_nbyte   = 4'(nxt);
                cmd_wdata   = 32'hC000_0000 + 32'(nxt);
            end
        end
        cmd_valid = 1'b0;
        check("wrap_accepted", 64'(nxt), 64'd9);
        check("wrap_full_again", {63'b0, cmd_ready}, 64'd0);
        for (int g = 0; g < 20 && exp_issue.size() > 0; g++) begin
            tick();
            ack_cycle(32'h0);
        end
        check("wrap_drained",  64'(exp_issue.size()), 64'd0);
        check("wrap_busy",     {63'b0, busy}, 64'd0);
        check("wrap_wr_count", {48'b0, wr_count}, 64'd14);

        // ---------------- simultaneous push and pop ----------------
        push_cmd(1'b0, 18'h00AAA, 4'b1010, 32'h0000_AAAA);
        cmd_valid   = 1'b1;
        cmd_rnw     = 1'b0;
        cmd_address = 18'h00BBB;
        cmd_nbyte   = 4'b1011;
        cmd_wdata   = 32'h0000_BBBB;
        exp_issue.push_back({1'b0, 18'h00BBB, 4'b1011, 32'h0000_BBBB});
        de_ack = 1'b1;
        tick();
        de_ack    = 1'b0;
        cmd_valid = 1'b0;
        check("pp_busy", {63'b0, busy},       64'd1);
        check("pp_head", {46'b0, de_address}, 64'h00BBB);
        tick();
        ack_cycle(32'h0);
        check("pp_empty", {63'b0, busy}, 64'd0);

        // ---------------- starvation ----------------
        push_cmd(1'b0, 18'h00055, 4'b0110, 32'h5555_0000);
        for (int i = 0; i < 7; i++) tick();
        check("starve_before", {63'b0, starve}, 64'd0);
        tick();
        check("starve_assert", {63'b0, starve}, 64'd1);
        tick();
        tick();
        check("starve_hold",   {63'b0, starve}, 64'd1);
        ack_cycle(32'h0);
        check("starve_clear",  {63'b0, starve}, 64'd0);
        check("starve_wr_count", {48'b0, wr_count}, 64'd17);

        // ---------------- stat_clear beats increment ----------------
        push_cmd(1'b0, 18'h00077, 4'b0001, 32'h7777_7777);
        tick();
        stat_clear = 1'b1;
        ack_cycle(32'h0);
        stat_clear = 1'b0;
        check("clr_counts", {32'b0, wr_count, rd_count}, 64'd0);
        push_cmd(1'b1, 18'h00007, 4'b0000, 32'h0);
        exp_rsp.push_back(32'h0BAD_F00D);
        tick();
        ack_cycle(32'h0BAD_F00D);
        check("clr_rd_count", {32'b0, wr_count, rd_count}, {32'b0, 16'd0, 16'd1});
        tick();

        // ---------------- reset mid-read ----------------
        push_cmd(1'b1, 18'h2AAAA, 4'b0011, 32'h0);
        tick();
        check("mr_req_before", {63'b0, de_req}, 64'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("mr_req_async",   {63'b0, de_req},    64'd0);
        check("mr_busy_async",  {63'b0, busy},      64'd0);
        check("mr_ready_async", {63'b0, cmd_ready}, 64'd1);
        exp_issue.delete();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        ack_cycle(32'hFFFF_FFFF);
        check("mr_no_rsp",  {63'b0, rsp_valid}, 64'd0);
        check("mr_counts",  {32'b0, wr_count, rd_count}, 64'd0);
        check("mr_nbyte",   {60'b0, de_nbyte}, 64'hF);
        tick();
        check("mr_no_rsp2", {63'b0, rsp_valid}, 64'd0);

        // ---------------- leftovers ----------------
        check("issue_q_empty", 64'(exp_issue.size()), 64'd0);
        check("rsp_q_empty",   64'(exp_rsp.size()),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/de_mem_scheduler.md
Name: de_mem_scheduler

Overview:
- Command queue and request sequencer between the drawing engine and the de_* client port of drawing_mem_ctrl.
- Buffers drawing-engine read/write commands and issues them in order using the memory controller's req/ack protocol:
  - the arbiter grants on alternate clock edges;
  - ack is a one-cycle pulse after the grant;
  - read data is sampled on the rising edge that ends the ack cycle.
- Returns read data to the drawing engine. Reports busy, starvation (the DE port has the lowest priority) and transfer statistics.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, 2..16).
- STARVE_LIMIT, 64, consecutive un-acked request cycles before starve asserts.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  drawing engine presents a command.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_address  in  18  word address.
- cmd_nbyte  in  4  active-low byte selects.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_data holds a read result.
- rsp_data  out  32  read data.
- de_req  out  1  request to the memory controller.
- de_ack  in  1  acknowledge from the memory controller.
- de_address  out  18  address to the memory controller.
- de_nbyte  out  4  byte selects to the memory controller.
- de_rnw  out  1  read/not-write to the memory controller.
- de_wdata  out  32  write data to the memory controller.
- de_rdata  in  32  read data from the memory controller.
- busy  out  1  FIFO non-empty.
- starve  out  1  request starvation flag.
- stat_clear  in  1  synchronous clear of the statistics counters.
- wr_count  out  16  completed writes, saturating.
- rd_count  out  16  completed reads, saturating.

Behaviour:
- Reset (nreset low, asynchronous) values:
  - FIFO pointers and count = 0.
  - de_req = 0, cmd_ready = 1, rsp_valid = 0, rsp_data = 0, busy = 0, starve = 0.
  - Starvation counter = 0, wr_count = 0, rd_count = 0.
  - de_address, de_nbyte, de_wdata and de_rnw reflect the (zeroed) head entry: 0, 4'b1111, 0, 0.
- Push: on a rising edge with cmd_valid && cmd_ready, the command is written at the tail.
- cmd_ready = (count < DEPTH), registered count only; no bypass on a same-cycle pop.
- Issue:
  - de_req = (count != 0).
  - de_address, de_nbyte, de_rnw and de_wdata are driven combinationally from the head entry.
  - de_nbyte is forced to 4'b1111 when empty.
- Pop: on a rising edge with de_req && de_ack, the head is retired.
  - The next entry appears on de_* in the following cycle, before the controller's next arbitration edge.
  - Back-to-back requests therefore keep de_req high continuously, with one transfer per two clocks at best.
- de_ack while de_req = 0 is ignored (no pop, no response).
- Read completion: on the pop edge of a read entry:
  - rsp_data <= de_rdata;
  - rsp_valid = 1 for exactly the next cycle;
  - rsp_data holds its value until the next read completes.
- Write completion: the pop edge only retires the entry; no response.
- Ordering: strictly FIFO. A read queued after writes observes those writes.
- Simultaneous push and pop: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Starvation counter:
  - increments each cycle with de_req && !de_ack, saturating at STARVE_LIMIT;
  - cleared on any pop or when the FIFO is empty.
  - starve = (counter == STARVE_LIMIT), registered.
  - starve deasserts on the cycle after the clearing pop.
- Statistics:
  - wr_count / rd_count increment on each write / read pop and saturate at 16'hFFFF.
  - stat_clear forces both to 0 and takes precedence over a same-cycle increment.
- busy = (count != 0).
- Reset mid-operation: the FIFO is flushed and de_req drops immediately (asynchronously).
  - A pending read produces no rsp_valid.
  - Any later de_ack is ignored.

Test Plan:
- Single write: push {wnr, addr 18'h00123, nbyte 4'b0000, data 32'hDEADBEEF}, ack pulse 2 cycles later → de_* match the command; wr_count = 1; busy = 0 and de_req = 0 the cycle after the ack.
- Back-to-back: push 4 writes to addr 0..3, ack every second cycle → de_req stays high for 8 cycles; addresses issued in order 0, 1, 2, 3; cmd_ready deasserts at count 4 and reasserts after the first pop.
- Read: push read addr 18'h3FFFF, ack with de_rdata = 32'hA5A5_5A5A → rsp_valid pulses once, one cycle after the ack edge, with rsp_data = 32'hA5A55A5A; rd_count = 1.
- Full and wrap: fill 4 entries, hold cmd_valid, then interleave a pop and a push for 10 cycles → no loss or duplication; FIFO order preserved across pointer wrap.
- Starvation: STARVE_LIMIT = 8, one queued entry, ack held low → starve asserts after 8 request cycles; ack → starve clears on the next cycle.
- Reset mid-read: drop nreset while a read is queued, then ack after release → de_req = 0 immediately; no rsp_valid; counters = 0.
